// File: rtl/mouse_click_ctl.sv
// mouse_click_ctl: debounces a mouse press and maps the cursor to a board cell.
// Cell coordinates come from repeated subtraction, one step per clock.
module mouse_click_ctl #(
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        left,
    input  logic        right,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic [11:0] board_xpos,
    input  logic [11:0] board_ypos,
    input  logic [5:0]  field_size,
    input  logic [4:0]  board_cols,
    input  logic [4:0]  board_rows,
    input  logic        enable,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [1:0]  ev_type,
    output logic [4:0]  ev_col,
    output logic [4:0]  ev_row,
    output logic        miss,
    output logic        busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    typedef enum logic [2:0] {IDLE, DEBOUNCE, CALC_X, CALC_Y, OUTPUT} state_t;
    state_t r_state, w_state;
    logic r_left_q, r_right_q, r_lock_l, r_lock_r, r_btn, r_miss;
    logic w_press_l, w_press_r, w_btn_lvl, w_ge, w_miss, w_latch;
    logic [1:0] r_type;
    logic [11:0] r_mx, r_my, r_bx, r_by, r_rem, w_rem;
    logic [5:0] r_fs;
    logic [4:0] r_cols, r_rows, r_col, r_row, w_col, w_row;
    logic [CW-1:0] r_cnt, w_cnt;
    // The lock keeps a button held through reset from counting as a fresh press.
    assign w_press_l = left & ~r_left_q & ~r_lock_l;
    assign w_press_r = right & ~r_right_q & ~r_lock_r;
    assign w_btn_lvl = r_btn ? right : left;
    assign w_ge      = r_rem >= {6'd0, r_fs};
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_rem   = r_rem;
        w_col   = r_col;
        w_row   = r_row;
        w_miss  = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            IDLE: if (enable && (w_press_l || w_press_r)) begin
                w_state = DEBOUNCE;
                w_cnt   = '0;
                w_latch = 1'b1;
            end
            DEBOUNCE: if (!w_btn_lvl) w_state = IDLE;
            else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                if (r_mx < r_bx || r_my < r_by || r_fs == 6'd0) begin
                    w_miss  = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_rem   = r_mx - r_bx;
                    w_col   = '0;
                    w_state = CALC_X;
                end
            end else w_cnt = r_cnt + 1'b1;
            CALC_X: if (w_ge) begin
                if (r_col + 5'd1 == r_cols) begin
                    w_miss  = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_rem = r_rem - {6'd0, r_fs};
                    w_col = r_col + 5'd1;
                end
            end else begin
                w_rem   = r_my - r_by;
                w_row   = '0;
                w_state = CALC_Y;
            end
            CALC_Y: if (w_ge) begin
                if (r_row + 5'd1 == r_rows) begin
                    w_miss  = 1'b1;
                    w_state = IDLE;
                end else begin
                    w_rem = r_rem - {6'd0, r_fs};
                    w_row = r_row + 5'd1;
                end
            end else w_state = OUTPUT;
            OUTPUT: if (ev_ready) w_state = IDLE;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_left_q  <= 1'b0;
            r_right_q <= 1'b0;
            r_lock_l  <= 1'b1;
            r_lock_r  <= 1'b1;
            r_miss    <= 1'b0;
            r_type    <= 2'b00;
            r_cnt     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rem     <= '0;
            r_btn     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_left_q  <= left;
            r_right_q <= right;
            r_lock_l  <= r_lock_l & left;
            r_lock_r  <= r_lock_r & right;
            r_miss    <= w_miss;
            r_cnt     <= w_cnt;
            r_col     <= w_col;
            r_row     <= w_row;
            r_rem     <= w_rem;
            if (w_latch) begin
                r_btn  <= ~w_press_l;
                r_type <= w_press_l ? 2'b01 : 2'b10;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_mx   <= mouse_xpos;
            r_my   <= mouse_ypos;
            r_bx   <= board_xpos;
            r_by   <= board_ypos;
            r_fs   <= field_size;
            r_cols <= board_cols;
            r_rows <= board_rows;
        end
    end
    assign ev_valid = (r_state == OUTPUT);
    assign busy     = (r_state != IDLE);
    assign miss     = r_miss;
    assign ev_type  = r_type;
    assign ev_col   = r_col;
    assign ev_row   = r_row;
endmodule
